// File: rtl/mips_pkg.sv
// Shared MIPS multicycle definitions: controller state codes, memory bus unit
// state codes and defaults, and small address helpers.
package mips_pkg;

    typedef enum logic [3:0] {
        CTRL_FETCH   = 4'd0,
        CTRL_DECODE  = 4'd1,
        CTRL_MEMADR  = 4'd2,
        CTRL_MEMRD   = 4'd3,
        CTRL_MEMWB   = 4'd4,
        CTRL_MEMWR   = 4'd5,
        CTRL_RTYPEEX = 4'd6,
        CTRL_RTYPEWB = 4'd7,
        CTRL_BEQEX   = 4'd8,
        CTRL_ADDIEX  = 4'd9,
        CTRL_ADDIWB  = 4'd10,
        CTRL_JEX     = 4'd11
    } ctrl_state_e;

    typedef enum logic [1:0] {
        MBU_IDLE = 2'd0,
        MBU_REQ  = 2'd1,
        MBU_DONE = 2'd2
    } mbu_state_e;

    localparam int unsigned MBU_TIMEOUT_DEF  = 15;
    localparam logic [31:0] MBU_ERR_DATA_DEF = 32'hDEAD_BEEF;
    localparam int unsigned MBU_CNT_W        = 8;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/mem_bus_unit_timeout.sv
// Request-phase cycle counter for the memory bus unit; flags the last cycle
// allowed before a transfer is aborted.
module mbu_timeout_counter
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT = MBU_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam logic [MBU_CNT_W-1:0] TC_VAL = MBU_CNT_W'(TIMEOUT - 1);

    logic [MBU_CNT_W-1:0] count_r;
    logic                 tc_s;

    // Count completed request cycles; cleared when a new transfer starts.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {MBU_CNT_W{1'b0}};
        end else if (clear) begin
            count_r <= {MBU_CNT_W{1'b0}};
        end else if (enable) begin
            count_r <= count_r + {{(MBU_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    // The current cycle is the TIMEOUT-th request cycle when TIMEOUT-1 have completed.
    always_comb begin
        tc_s = 1'b0;
        if (enable && (count_r == TC_VAL)) begin
            tc_s = 1'b1;
        end else begin
            tc_s = 1'b0;
        end
    end

    assign tc = tc_s;

endmodule

// File: rtl/mem_bus_unit.sv
// Memory bus unit: turns multicycle-controller read/write requests into
// single external bus transfers, stalling the core until completion.
module mem_bus_unit
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT  = MBU_TIMEOUT_DEF,
    parameter logic [31:0] ERR_DATA = MBU_ERR_DATA_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        IorD,
    input  logic [31:0] pc,
    input  logic [31:0] alu_out,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    mbu_state_e  state_r;
    mbu_state_e  state_nxt_s;

    logic [31:0] sel_addr_s;
    logic        aligned_s;
    logic        single_s;
    logic        conflict_s;

    logic        stall_s;
    logic        start_s;
    logic        bad_addr_s;
    logic        conflict_hit_s;
    logic        ack_hit_s;
    logic        abort_s;
    logic        cnt_en_s;
    logic        tc_s;

    logic [31:0] rdata_r;
    logic        fault_r;
    logic        bus_req_r;
    logic        bus_we_r;
    logic [31:0] bus_addr_r;
    logic [31:0] bus_wdata_r;

    assign sel_addr_s = IorD ? alu_out : pc;
    assign aligned_s  = is_word_aligned(sel_addr_s);
    assign single_s   = mem_read ^ mem_write;
    assign conflict_s = mem_read & mem_write;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= MBU_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; ack wins over timeout in the same cycle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            MBU_IDLE: begin
                if (conflict_s) begin
                    state_nxt_s = MBU_DONE;
                end else if (single_s) begin
                    state_nxt_s = aligned_s ? MBU_REQ : MBU_DONE;
                end else begin
                    state_nxt_s = MBU_IDLE;
                end
            end
            MBU_REQ: begin
                if (bus_ack || tc_s) begin
                    state_nxt_s = MBU_DONE;
                end else begin
                    state_nxt_s = MBU_REQ;
                end
            end
            MBU_DONE: state_nxt_s = MBU_IDLE;
            default:  state_nxt_s = MBU_IDLE;
        endcase
    end

    // Output and event decode per state; bus_ack outside REQ never reaches ack_hit_s.
    always_comb begin
        stall_s        = 1'b0;
        start_s        = 1'b0;
        bad_addr_s     = 1'b0;
        conflict_hit_s = 1'b0;
        ack_hit_s      = 1'b0;
        abort_s        = 1'b0;
        cnt_en_s       = 1'b0;
        case (state_r)
            MBU_IDLE: begin
                stall_s        = mem_read | mem_write;
                start_s        = single_s & aligned_s;
                bad_addr_s     = single_s & ~aligned_s;
                conflict_hit_s = conflict_s;
            end
            MBU_REQ: begin
                stall_s   = 1'b1;
                cnt_en_s  = 1'b1;
                ack_hit_s = bus_ack;
                abort_s   = ~bus_ack & tc_s;
            end
            MBU_DONE: begin
                stall_s = 1'b0;
            end
            default: begin
                stall_s = 1'b0;
            end
        endcase
    end

    mbu_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (start_s),
        .enable (cnt_en_s),
        .tc     (tc_s)
    );

    // Bus request tracks the REQ state one-for-one, so reset drops it at the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_req_r <= 1'b0;
        end else begin
            bus_req_r <= (state_nxt_s == MBU_REQ);
        end
    end

    // Transfer attributes are captured once at request time and held through REQ.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_we_r    <= 1'b0;
            bus_addr_r  <= 32'h0000_0000;
            bus_wdata_r <= 32'h0000_0000;
        end else if (start_s) begin
            bus_we_r    <= mem_write;
            bus_addr_r  <= sel_addr_s;
            bus_wdata_r <= wdata;
        end else begin
            bus_we_r    <= bus_we_r;
            bus_addr_r  <= bus_addr_r;
            bus_wdata_r <= bus_wdata_r;
        end
    end

    // Read result: bus data on ack, error pattern on aborted or misaligned reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r <= 32'h0000_0000;
        end else if (ack_hit_s && !bus_we_r) begin
            rdata_r <= bus_rdata;
        end else if ((abort_s && !bus_we_r) || (bad_addr_s && mem_read)) begin
            rdata_r <= ERR_DATA;
        end else begin
            rdata_r <= rdata_r;
        end
    end

    // Sticky fault: only rst clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_r <= 1'b0;
        end else if (abort_s || bad_addr_s || conflict_hit_s) begin
            fault_r <= 1'b1;
        end else begin
            fault_r <= fault_r;
        end
    end

    assign stall     = stall_s;
    assign rdata     = rdata_r;
    assign fault     = fault_r;
    assign bus_req   = bus_req_r;
    assign bus_we    = bus_we_r;
    assign bus_addr  = bus_addr_r;
    assign bus_wdata = bus_wdata_r;

endmodule

// File: tb/tb_mem_bus_unit.sv
// Directed self-checking bench for mem_bus_unit: fetch, store, back-to-back,
// timeout, sticky fault, misaligned, reset during REQ and rd/wr conflict.
module tb_mem_bus_unit;

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic        IorD;
    logic [31:0] pc;
    logic [31:0] alu_out;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        fault;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int checks_cnt;
    int errors_cnt;

    int          lat;
    int          req_n;
    int          unstable;
    logic [31:0] addr_v;
    logic        we_v;
    logic [31:0] wdat_v;

    mem_bus_unit dut (
        .clk       (clk),
        .rst       (rst),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .IorD      (IorD),
        .pc        (pc),
        .alu_out   (alu_out),
        .wdata     (wdata),
        .rdata     (rdata),
        .stall     (stall),
        .fault     (fault),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one request, answer with an ack in REQ cycle ack_at (0 = never), stop in DONE.
    task automatic run_access(input logic rd, input logic wr, input logic iord,
                              input logic [31:0] pc_v, input logic [31:0] alu_v,
                              input logic [31:0] wd_v, input int ack_at,
                              input logic [31:0] ack_data,
                              output int lat_o, output int req_o,
                              output logic [31:0] addr_o, output logic we_o,
                              output logic [31:0] wdat_o, output int unst_o);
        @(posedge clk); #1;
        mem_read  = rd;
        mem_write = wr;
        IorD      = iord;
        pc        = pc_v;
        alu_out   = alu_v;
        wdata     = wd_v;
        bus_ack   = 1'b0;
        @(negedge clk);
        lat_o  = 0;
        req_o  = 0;
        unst_o = 0;
        addr_o = 32'h0;
        we_o   = 1'b0;
        wdat_o = 32'h0;
        chk("idle_stall", {31'h0, stall}, 32'h1);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            bus_ack   = bus_req && (req_o + 1 == ack_at);
            bus_rdata = bus_ack ? ack_data : 32'h0F0F_0F0F;
            @(negedge clk);
            lat_o++;
            if (bus_req) begin
                if (req_o == 0) begin
                    addr_o = bus_addr;
                    we_o   = bus_we;
                    wdat_o = bus_wdata;
                end else if (bus_addr !== addr_o || bus_we !== we_o || bus_wdata !== wdat_o) begin
                    unst_o++;
                end
                req_o++;
            end
            if (!stall) break;
        end
        chk("done_reached", {31'h0, stall}, 32'h0);
    endtask

    // Drop the request; optionally pulse a stray ack while idle.
    task automatic idle_gap(input logic spur);
        @(posedge clk); #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        bus_ack   = spur;
        bus_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        chk("gap_stall", {31'h0, stall}, 32'h0);
        chk("gap_req", {31'h0, bus_req}, 32'h0);
        @(posedge clk); #1;
        bus_ack = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        mem_read = 1'b0; mem_write = 1'b0; bus_ack = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        checks_cnt = 0;
        errors_cnt = 0;
        rst = 1'b1;
        mem_read = 1'b0; mem_write = 1'b0; IorD = 1'b0;
        pc = 32'h0; alu_out = 32'h0; wdata = 32'h0;
        bus_ack = 1'b0; bus_rdata = 32'h0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_fault", {31'h0, fault}, 32'h0);
        chk("rst_bus_req", {31'h0, bus_req}, 32'h0);
        chk("rst_bus_we", {31'h0, bus_we}, 32'h0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_bus_wdata", bus_wdata, 32'h0);
        chk("rst_stall", {31'h0, stall}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Fetch with ack in 3rd REQ cycle.
        run_access(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 3, 32'h8C22_0004,
                   lat, req_n, addr_v, we_v, wdat_v, unstable);
        chk("fetch_lat", lat, 32'd4);
        chk("fetch_req_n", req_n, 32'd3);
        chk("fetch_addr", addr_v, 32'h40);
        chk("fetch_we", {31'h0, we_v}, 32'h0);
        chk("fetch_stable", unstable, 32'd0);
        chk("fetch_rdata", rdata, 32'h8C22_0004);
        chk("fetch_fault", {31'h0, fault}, 32'h0);
        idle_gap(1'b0);

        // Store, minimum latency; ack data must not reach rdata.
        run_access(1'b0, 1'b1, 1'b1, 32'h44, 32'h100, 32'h55, 1, 32'h1234_5678,
                   lat, req_n, addr_v, we_v, wdat_v, unstable);
        chk("store_lat", lat, 32'd2);
        chk("store_req_n", req_n, 32'd1);
        chk("store_addr", addr_v, 32'h100);
        chk("store_we", {31'h0, we_v}, 32'h1);
        chk("store_wdata", wdat_v, 32'h55);
        chk("store_rdata", rdata, 32'h8C22_0004);
        chk("store_fault", {31'h0, fault}, 32'h0);
        idle_gap(1'b0);

        // Back-to-back: lw fetch, stray ack while idle, then data read.
        run_access(1'b1, 1'b0, 1'b0, 32'h44, 32'h0, 32'h0, 1, 32'h8C43_0200,
                   lat, req_n, addr_v, we_v, wdat_v, unstable);
        chk("b2b_f_addr", addr_v, 32'h44);
        chk("b2b_f_rdata", rdata, 32'h8C43_0200);
        idle_gap(1'b1);
        chk("b2b_spur_rdata", rdata, 32'h8C43_0200);
        run_access(1'b1, 1'b0, 1'b1, 32'h48, 32'h200, 32'h0, 2, 32'hCAFE_F00D,
                   lat, req_n, addr_v, we_v, wdat_v, unstable);
        chk("b2b_d_addr", addr_v, 32'h200);
        chk("b2b_d_req_n", req_n, 32'd2);
        chk("b2b_d_rdata", rdata, 32'hCAFE_F00D);
        chk("b2b_fault", {31'h0, fault}, 32'h0);
        idle_gap(1'b0);

        // Timeout: no ack at all.
        run_access(1'b1, 1'b0, 1'b0, 32'h80, 32'h0, 32'h0, 0, 32'h0,
                   lat, req_n, addr_v, we_v, wdat_v, unstable);
        chk("to_req_n", req_n, 32'd15);
        chk("to_lat", lat, 32'd16);
        chk("to_fault", {31'h0, fault}, 32'h1);
        chk("to_rdata", rdata, 32'hDEAD_BEEF);
        idle_gap(1'b0);

        // Fault stays set across a clean read.
        run_access(1'b1, 1'b0, 1'b0, 32'h84, 32'h0, 32'h0, 1, 32'h1111_2222,
                   lat, req_n, addr_v, we_v, wdat_v, unstable);
        chk("sticky_fault", {31'h0, fault}, 32'h1);
        chk("sticky_rdata", rdata, 32'h1111_2222);
        idle_gap(1'b0);

        // Misaligned data read.
        do_reset();
        @(negedge clk);
        chk("rst2_fault", {31'h0, fault}, 32'h0);
        run_access(1'b1, 1'b0, 1'b1, 32'h0, 32'h102, 32'h0, 1, 32'h3333_4444,
                   lat, req_n, addr_v, we_v, wdat_v, unstable);
        chk("mis_req_n", req_n, 32'd0);
        chk("mis_lat", lat, 32'd1);
        chk("mis_fault", {31'h0, fault}, 32'h1);
        chk("mis_rdata", rdata, 32'hDEAD_BEEF);
        idle_gap(1'b0);

        // Reset in the 2nd REQ cycle, then a late ack.
        @(posedge clk); #1;
        mem_read = 1'b1; IorD = 1'b0; pc = 32'h60;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_req_before", {31'h0, bus_req}, 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mem_read = 1'b0;
        bus_ack = 1'b1;
        bus_rdata = 32'h7777_7777;
        @(negedge clk);
        chk("mid_req_drop", {31'h0, bus_req}, 32'h0);
        chk("mid_stall", {31'h0, stall}, 32'h0);
        @(posedge clk); #1;
        bus_ack = 1'b0;
        @(negedge clk);
        chk("mid_rdata", rdata, 32'h0);
        chk("mid_fault", {31'h0, fault}, 32'h0);
        chk("mid_req_after", {31'h0, bus_req}, 32'h0);

        // Read and write together.
        run_access(1'b1, 1'b1, 1'b0, 32'h90, 32'h0, 32'h0, 1, 32'h5555_6666,
                   lat, req_n, addr_v, we_v, wdat_v, unstable);
        chk("cfl_req_n", req_n, 32'd0);
        chk("cfl_lat", lat, 32'd1);
        chk("cfl_fault", {31'h0, fault}, 32'h1);
        idle_gap(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
